// File: rtl/da_bit_serial_mac.sv
// Bit-serial distributed-arithmetic MAC for one DCT coefficient row.
// Serialises four samples MSB-first into an odd-symmetric Z0 ROM and shift-accumulates the returned words.
module da_bit_serial_mac #(
   parameter  int DATA_W = 16,
   parameter  int ROM_W  = 16,
   localparam int ACC_W  = ROM_W + DATA_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x0,
   input  logic [DATA_W-1:0] x1,
   input  logic [DATA_W-1:0] x2,
   input  logic [DATA_W-1:0] x3,
   output logic [2:0]        rom_addr,
   output logic              rom_cs,
   input  logic [ROM_W-1:0]  rom_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  y
);

   localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                    state;
   state_t                    state_next;
   logic [DATA_W-1:0]         sr [4];
   logic [CNT_W-1:0]          cnt;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_next;
   logic signed [ACC_W-1:0]   rom_sext;
   logic signed [ACC_W-1:0]   term;
   logic                      b0;
   logic [2:0]                b_rest;

   assign b0     = sr[0][DATA_W-1];
   assign b_rest = {sr[1][DATA_W-1], sr[2][DATA_W-1], sr[3][DATA_W-1]};

   // Only the b0=0 half is stored; the b0=1 half is the negated word at the complemented address.
   assign rom_sext = {{(ACC_W - ROM_W){rom_data[ROM_W-1]}}, rom_data};
   assign term     = b0 ? -rom_sext : rom_sext;

   // The first serial bit is the sign bit and carries negative weight.
   assign acc_next = (cnt == CNT_LAST) ? -term : ((acc <<< 1) + term);

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path leaves one unassigned and infers a latch.
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      rom_cs     = 1'b0;
      rom_addr   = 3'b000;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            rom_cs   = 1'b1;
            rom_addr = b0 ? ~b_rest : b_rest;
            if (cnt == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         y     <= '0;
         for (int k = 0; k < 4; k++) begin
            sr[k] <= '0;
         end
      end else begin
         state <= state_next;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sr[0] <= x0;
                  sr[1] <= x1;
                  sr[2] <= x2;
                  sr[3] <= x3;
                  acc   <= '0;
                  cnt   <= CNT_LAST;
               end
            end
            RUN: begin
               for (int k = 0; k < 4; k++) begin
                  sr[k] <= sr[k] << 1;
               end
               acc <= acc_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  y <= acc_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/da_bit_serial_mac.md
Name: da_bit_serial_mac

Overview:
- Bit-serial distributed-arithmetic (DA) engine for one DCT output coefficient.
- Accepts four signed samples x0..x3, serialises them MSB-first and drives the 3-bit address and chip select of the downstream Z0 coefficient ROM.
- Shift-accumulates the returned 16-bit ROM words into a full-precision coefficient.
- Sits between the sample buffer and the RLE quantiser/encoder. One instance exists per ROM row.

Parameters:
- DATA_W, 16, sample width in bits (two's complement); also the number of serial cycles.
- ROM_W, 16, ROM word width, signed Q2.14.
- ACC_W, ROM_W+DATA_W+1, accumulator and result width (derived, not overridable).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample set valid.
- in_ready  out  1  engine can accept a sample set.
- x0, x1, x2, x3  in  DATA_W each  signed input samples.
- rom_addr  out  3  Z0 ROM address.
- rom_cs  out  1  Z0 ROM chip select.
- rom_data  in  ROM_W  Z0 ROM word; combinational response to rom_addr/rom_cs in the same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  ACC_W  signed coefficient, Q(ACC_W-14).14.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; rom_cs=0; rom_addr=0; y=0; accumulator=0; bit counter=0; shift registers=0.
- States:
  - IDLE: in_ready=1. When in_valid&in_ready, capture x0..x3 into shift registers, set acc=0, set cnt=DATA_W-1, go to RUN.
  - RUN: lasts exactly DATA_W cycles. rom_cs=1. bj = current MSB of each shift register.
    - If b0=0: rom_addr={b1,b2,b3}, term=+rom_data.
    - If b0=1: rom_addr=~{b1,b2,b3}, term=-rom_data. The ROM is odd-symmetric, so only the Z0 half is stored.
    - First RUN cycle (sign bit, cnt=DATA_W-1): acc = -sext(term).
    - Other cycles: acc = (acc<<1) + sext(term).
    - Shift registers shift left by 1 each RUN cycle. cnt decrements.
    - When cnt=0, register y=acc_next, go to DONE.
  - DONE: out_valid=1, rom_cs=0, in_ready=0. On out_ready go to IDLE. out_valid drops the next cycle.
- Result definition: y = -term_{W-1}*2^(W-1) + sum over j<W-1 of term_j*2^j, where j is the bit index. Exact; no rounding or saturation. ACC_W is sufficient by construction.
- Arithmetic width rules: rom_data is sign-extended to ACC_W before add/negate. Negating -2^15 is exact in ACC_W.
- Latency: handshake in cycle t; RUN occupies t+1..t+DATA_W; out_valid first high at t+DATA_W+1. Throughput is one set per DATA_W+2 cycles with out_ready held high.
- rom_addr and rom_cs are combinational from state and shift registers. They are glitch-tolerant; the ROM output is sampled only at the rising edge.
- y is held stable while out_valid=1. Inputs are ignored outside IDLE. x0..x3 may change freely after capture.
- Outside RUN, rom_addr=0 and rom_cs=0. With cs low the ROM returns 0, so any stray add is harmless.
- Reset asserted mid-RUN or in DONE aborts immediately. The partial result is discarded and not presented.
- in_valid held high in DONE while out_ready=1: the engine returns to IDLE first; acceptance happens the following cycle. There is no same-cycle bypass.

Test Plan:
1. Reset then x0..x3=0, in_valid for 1 cycle, out_ready=1, Z0 ROM model attached -> rom_cs high 16 cycles, rom_addr=000 each cycle, out_valid 17 cycles after handshake, y=+23171.
2. x0=-1 (0xFFFF), x1=x2=x3=0 -> rom_addr=111 every RUN cycle, term=-11585 each, y=+11585.
3. x0=0, x1=x2=x3=0x7FFF -> cycle 1 addr=000 (sign bits), cycles 2-16 addr=111. y equals the golden-model value from the formula; the bench model checks the exact 33-bit result.
4. Hold out_ready=0 for 10 cycles after out_valid -> out_valid and y stable, in_ready=0, rom_cs=0. Release -> out_valid low the next cycle, in_ready=1.
5. Assert rst for 1 cycle at RUN cycle 8 -> all outputs at reset values immediately. A new sample set then completes normally with the correct y.
6. 20 back-to-back random sample sets with in_valid always high and random out_ready -> every y matches the golden DA model, and no sample set is lost or duplicated.
